fp_serial_ctrl: RTL
===================

FP_SERIAL_CTRL -- requirements
Module: fp_serial_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles spent in WAIT for add_done before an error is flagged (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin one serial add transaction.
REQ-005 The block SHALL have port din, input, 1, serial operand bit stream, MSB first; the same wire also feeds the operand-A and operand-B shift registers directly.
REQ-006 The block SHALL have port lda, output, 1, shift enable for the operand-A register.
REQ-007 The block SHALL have port ldb, output, 1, shift enable for the operand-B register.
REQ-008 The block SHALL have port add_start, output, 1, single-cycle launch pulse to the adder core.
REQ-009 The block SHALL have port add_done, input, 1, adder-core completion strobe; result is valid in that same cycle.
REQ-010 The block SHALL have port result, input, 32, adder-core sum, sampled only when add_done=1 in WAIT.
REQ-011 The block SHALL have port dout, output, 1, serial result bit, MSB first.
REQ-012 The block SHALL have port dout_valid, output, 1, qualifies dout.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1, single-cycle end-of-transaction pulse.
REQ-015 The block SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, LAUNCH, WAIT, SHIFT_OUT and FIN, all encoded registered.
REQ-017 In IDLE, start=1 at a clock edge SHALL move the FSM to LOAD_A, clear err and clear the 5-bit bit counter; start SHALL be ignored in every other state.
REQ-018 LOAD_A SHALL last exactly 32 cycles with lda=1 and ldb=0; din bit 31 of A SHALL be present in the first LOAD_A cycle.
REQ-019 After the counter wraps 31->0, the FSM SHALL enter LOAD_B, which lasts exactly 32 cycles with ldb=1 and lda=0, MSB of B first.
REQ-020 LAUNCH SHALL last 1 cycle with add_start=1, then move to WAIT.
REQ-021 In WAIT, add_done=1 SHALL load result into a 32-bit output shift register and move to SHIFT_OUT.
REQ-022 A WAIT cycle counter SHALL start at 0 on entry; if TIMEOUT cycles elapse without add_done, the block SHALL set err=1 and go to FIN without asserting dout_valid.
REQ-023 If add_done and the timeout occur in the same cycle, add_done SHALL win.
REQ-024 SHIFT_OUT SHALL last exactly 32 cycles with dout_valid=1 and dout equal to the shift register MSB, shifting left by one bit each cycle, so bit 31 of result appears in the first cycle.
REQ-025 FIN SHALL last 1 cycle with done=1, then return to IDLE; if start=1 in FIN it SHALL be ignored.
REQ-026 lda, ldb, add_start, dout_valid, done and busy SHALL be Moore outputs decoded from registered state only.
REQ-027 dout SHALL be 0 whenever dout_valid=0.
REQ-028 add_done outside WAIT SHALL be ignored.
REQ-029 Transaction length without a timeout SHALL be 1+32+32+1+N_wait+32+1 cycles from the start edge to return to IDLE.

Reset
REQ-030 Reset SHALL act immediately at any time, including mid-transaction: state=IDLE, counters=0, shift register=0, err=0.
REQ-031 During and after reset, all outputs SHALL be 0 until the next start.
REQ-032 A reset asserted during LOAD_A, LOAD_B or SHIFT_OUT SHALL drop lda, ldb or dout_valid in that same cycle, without waiting for a clock edge.

Verification
REQ-033 Basic add: A=0x3F800000, B=0x40000000, adder model returns 0x40400000 3 cycles after add_start -> lda high for 32 cycles, then ldb high for 32 cycles, add_start pulses once, dout streams 0x40400000 MSB first under 32 dout_valid cycles, done pulses once, err=0.
REQ-034 Timeout: add_done held 0, TIMEOUT=64 -> err=1 after 64 WAIT cycles, dout_valid never asserted, done pulses once, busy falls, err stays 1 until the next start.
REQ-035 Start while busy: pulse start during LOAD_B and during SHIFT_OUT -> no state change and the transaction completes normally.
REQ-036 Reset mid-load: assert reset in cycle 10 of LOAD_A -> all outputs 0 immediately; a following transaction with A=0xFFFFFFFF, B=0x00000001 and result 0x12345678 streams 0x12345678 correctly.
REQ-037 Race and stray strobe: add_done asserted in the same cycle as timeout expiry -> result shifted out and err=0; add_done pulsed during IDLE -> no effect.
REQ-038 Back-to-back: start held high continuously -> the second transaction begins in the cycle after FIN returns to IDLE, and no cycles overlap between the two transactions.

Source files
------------

// File: rtl/fp_serial_ctrl.sv
// rtl/fp_serial_ctrl.sv - serial load / launch / shift-out controller for a 32-bit adder core
module fp_serial_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        din,
    output logic        lda,
    output logic        ldb,
    output logic        add_start,
    input  logic        add_done,
    input  logic [31:0] result,
    output logic        dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_A    = 3'd1;
    localparam logic [2:0] S_LOAD_B    = 3'd2;
    localparam logic [2:0] S_LAUNCH    = 3'd3;
    localparam logic [2:0] S_WAIT      = 3'd4;
    localparam logic [2:0] S_SHIFT_OUT = 3'd5;
    localparam logic [2:0] S_FIN       = 3'd6;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [7:0]  wait_cnt;
    logic [31:0] out_sreg;

    // din is wired straight to the operand registers outside this block
    logic unused_din;
    assign unused_din = din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= 5'd0;
            wait_cnt <= 8'd0;
            out_sreg <= 32'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_LOAD_A;
                        bit_cnt <= 5'd0;
                        err     <= 1'b0;
                    end
                end
                S_LOAD_A: begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wait_cnt <= 8'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // a completion strobe in the final timeout cycle still wins
                    if (add_done) begin
                        out_sreg <= result;
                        bit_cnt  <= 5'd0;
                        state    <= S_SHIFT_OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_SHIFT_OUT: begin
                    out_sreg <= {out_sreg[30:0], 1'b0};
                    bit_cnt  <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign lda        = (state == S_LOAD_A);
    assign ldb        = (state == S_LOAD_B);
    assign add_start  = (state == S_LAUNCH);
    assign dout_valid = (state == S_SHIFT_OUT);
    assign done       = (state == S_FIN);
    assign busy       = (state != S_IDLE);
    assign dout       = dout_valid & out_sreg[31];

endmodule
